// File: rtl/iir_seq_pkg.sv
// Shared types and constants for the time-multiplexed 16th-order IIR filter.
// Holds the sequencer state encoding, the default widths and the fixed
// coefficient tables (a1..a16 feedback, b0..b16 feedforward, Q.7 signed).
package iir_seq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FB   = 3'd1,
        NORM = 3'd2,
        FF   = 3'd3,
        OUT  = 3'd4
    } state_t;

    localparam int DEF_ORDER     = 16;
    localparam int DEF_IN_W      = 8;
    localparam int DEF_COEF_W    = 10;
    localparam int DEF_COEF_FRAC = 7;
    localparam int DEF_STATE_W   = 16;
    localparam int DEF_OUT_W     = 18;
    localparam int DEF_ACC_W     = 36;

    // Feedback taps a1..a16.
    localparam logic signed [DEF_COEF_W-1:0] A_COEF [1:DEF_ORDER] = '{
        10'h080, 10'h373, 10'h14C, 10'h2D6, 10'h1E5, 10'h297, 10'h1AA, 10'h2FA,
        10'h0FA, 10'h384, 10'h060, 10'h3DB, 10'h018, 10'h3FA, 10'h003, 10'h000
    };

    // Feedforward taps b0..b16 (symmetric, odd taps zero).
    localparam logic signed [DEF_COEF_W-1:0] B_COEF [0:DEF_ORDER] = '{
        10'h006, 10'h000, 10'h3D2, 10'h000, 10'h0A1, 10'h000, 10'h2BE, 10'h000,
        10'h193,
        10'h000, 10'h2BE, 10'h000, 10'h0A1, 10'h000, 10'h3D2, 10'h000, 10'h006
    };

endpackage

// File: rtl/iir_coef_rom.sv
// Coefficient lookup for the shared MAC: phase 0 selects a_k (feedback pass),
// phase 1 selects b_k (feedforward pass). Out-of-range indices return zero.
module iir_coef_rom
    import iir_seq_pkg::*;
#(
    parameter int K_W = 5
) (
    input  logic                         phase,
    input  logic [K_W-1:0]               k,
    output logic signed [DEF_COEF_W-1:0] coef
);

    // Pure table lookup; a_0 does not exist so index 0 in the feedback phase is zero.
    always_comb begin
        coef = '0;
        if (phase) begin
            if (int'(k) <= DEF_ORDER) coef = B_COEF[k];
        end else begin
            if (k != '0 && int'(k) <= DEF_ORDER) coef = A_COEF[k];
        end
    end

endmodule

// File: rtl/iir_mac_sequencer.sv
// Direct-form-II IIR filter built around one multiply-accumulate unit.
// Per sample: load x<<FRAC, subtract a_k*w[k] for k=1..ORDER, normalise into
// w_new, accumulate b_k*w for k=0..ORDER, then hold the result in OUT until
// the consumer takes it; the delay line shifts only on that handshake.
// Build option: define IIR_SEQ_SAT_EN to clamp the state/output conversions
// and drive the sticky sat flag; otherwise conversions wrap and sat is 0.
module iir_mac_sequencer
    import iir_seq_pkg::*;
#(
    parameter int ORDER     = DEF_ORDER,
    parameter int IN_W      = DEF_IN_W,
    parameter int COEF_W    = DEF_COEF_W,
    parameter int COEF_FRAC = DEF_COEF_FRAC,
    parameter int STATE_W   = DEF_STATE_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int ACC_W     = DEF_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    sat
);

    localparam int K_W    = $clog2(ORDER + 1);
    localparam int PROD_W = COEF_W + STATE_W;

    state_t                     state, state_nx;
    logic [K_W-1:0]             k;
    logic                       k_last;
    logic signed [ACC_W-1:0]    acc;
    logic signed [STATE_W-1:0]  w [1:ORDER];
    logic signed [STATE_W-1:0]  w_new;
    logic signed [COEF_W-1:0]   coef;
    logic signed [STATE_W-1:0]  w_sel;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    in_ext;
    logic signed [ACC_W-1:0]    acc_diff;
    logic signed [ACC_W-1:0]    acc_sum;
    logic signed [ACC_W-1:0]    acc_shr;
    logic signed [ACC_W-1:0]    sum_shr;

`ifdef IIR_SEQ_SAT_EN
    localparam logic signed [ACC_W-1:0] STATE_MAX = {{(ACC_W-STATE_W+1){1'b0}}, {(STATE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] STATE_MIN = {{(ACC_W-STATE_W+1){1'b1}}, {(STATE_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] OUT_MAX   = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN   = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    function automatic logic state_clamps(input logic signed [ACC_W-1:0] v);
        return (v > STATE_MAX) || (v < STATE_MIN);
    endfunction

    function automatic logic out_clamps(input logic signed [ACC_W-1:0] v);
        return (v > OUT_MAX) || (v < OUT_MIN);
    endfunction

    function automatic logic signed [STATE_W-1:0] sat_state(input logic signed [ACC_W-1:0] v);
        if (v > STATE_MAX) return STATE_MAX[STATE_W-1:0];
        if (v < STATE_MIN) return STATE_MIN[STATE_W-1:0];
        return v[STATE_W-1:0];
    endfunction

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        if (v > OUT_MAX) return OUT_MAX[OUT_W-1:0];
        if (v < OUT_MIN) return OUT_MIN[OUT_W-1:0];
        return v[OUT_W-1:0];
    endfunction
`else
    function automatic logic signed [STATE_W-1:0] sat_state(input logic signed [ACC_W-1:0] v);
        return v[STATE_W-1:0];
    endfunction

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        return v[OUT_W-1:0];
    endfunction
`endif

    iir_coef_rom #(
        .K_W (K_W)
    ) u_rom (
        .phase (state == FF),
        .k     (k),
        .coef  (coef)
    );

    assign k_last    = (k == K_W'(ORDER));
    assign in_ready  = (state == IDLE) && !flush;
    assign busy      = (state != IDLE);
    assign out_valid = (state == OUT);

    // MAC operand: the fresh w[n] feeds tap b0, every other tap reads the delay line.
    always_comb begin
        w_sel = w_new;
        if (k != '0) w_sel = w[k];
    end

    assign prod     = PROD_W'(coef) * PROD_W'(w_sel);
    assign prod_ext = ACC_W'(prod);
    assign in_ext   = ACC_W'(in_data) <<< COEF_FRAC;
    assign acc_diff = acc - prod_ext;
    assign acc_sum  = acc + prod_ext;
    assign acc_shr  = acc >>> COEF_FRAC;
    assign sum_shr  = acc_sum >>> COEF_FRAC;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid && in_ready) state_nx = FB;
            FB:   if (k_last) state_nx = NORM;
            NORM: state_nx = FF;
            FF:   if (k_last) state_nx = OUT;
            OUT:  if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    // Tap counter, accumulator and w[n] register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k     <= '0;
            acc   <= '0;
            w_new <= '0;
        end else if (flush) begin
            k     <= '0;
            acc   <= '0;
            w_new <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    acc <= in_ext;
                    k   <= K_W'(1);
                end
                FB: begin
                    acc <= acc_diff;
                    k   <= k + K_W'(1);
                end
                NORM: begin
                    w_new <= sat_state(acc_shr);
                    acc   <= '0;
                    k     <= '0;
                end
                FF: begin
                    acc <= acc_sum;
                    if (!k_last) k <= k + K_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Delay line advances only when the output handshake completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i <= ORDER; i++) w[i] <= '0;
        end else if (flush) begin
            for (int i = 1; i <= ORDER; i++) w[i] <= '0;
        end else if (state == OUT && out_ready) begin
            w[1] <= w_new;
            for (int i = 2; i <= ORDER; i++) w[i] <= w[i-1];
        end
    end

    // Output register, loaded with the last feedforward term included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        out_data <= '0;
        else if (state == FF && k_last)  out_data <= sat_out(sum_shr);
    end

`ifdef IIR_SEQ_SAT_EN
    // Sticky clamp indicator, cleared only by flush or reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        sat <= 1'b0;
        else if (flush)  sat <= 1'b0;
        else if (state == NORM && state_clamps(acc_shr))         sat <= 1'b1;
        else if (state == FF && k_last && out_clamps(sum_shr))   sat <= 1'b1;
    end
`else
    assign sat = 1'b0;
`endif

endmodule

// File: tb/tb_iir_mac_sequencer.sv
// Self-checking bench for iir_mac_sequencer with a behavioural DF-II model
// feeding a scoreboard of expected outputs.
module tb_iir_mac_sequencer;
    import iir_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic signed [7:0]  in_data;
    logic in_valid;
    logic in_ready;
    logic signed [17:0] out_data;
    logic out_valid;
    logic out_ready;
    logic busy;
    logic sat;

    logic flush2;
    logic signed [7:0] in_data2;
    logic in_valid2;
    logic in_ready2;
    logic signed [7:0] out_data2;
    logic out_valid2;
    logic out_ready2;
    logic busy2;
    logic sat2;

    int checks = 0;
    int failures = 0;

    logic signed [17:0] sb[$];

    int A_M [1:16] = '{128, -141, 332, -298, 485, -361, 426, -262,
                       250, -124, 96, -37, 24, -6, 3, 0};
    int B_M [0:16] = '{6, 0, -46, 0, 161, 0, -322, 0, 403,
                       0, -322, 0, 161, 0, -46, 0, 6};
    longint mw [1:16];
    longint m_wnew;
    logic   m_sat;

    always #5 clk = ~clk;

    iir_mac_sequencer dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .sat(sat)
    );

    iir_mac_sequencer #(.COEF_FRAC(0), .OUT_W(8)) dut2 (
        .clk(clk), .rst(rst), .flush(flush2),
        .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .busy(busy2), .sat(sat2)
    );

    function automatic longint conv(longint v, int wdt);
        longint hi = (64'sd1 <<< (wdt - 1)) - 1;
        longint lo = -hi - 1;
`ifdef IIR_SEQ_SAT_EN
        if (v > hi) begin m_sat = 1'b1; return hi; end
        if (v < lo) begin m_sat = 1'b1; return lo; end
        return v;
`else
        longint m = v & ((64'sd1 <<< wdt) - 1);
        if (m > hi) m = m - (64'sd1 <<< wdt);
        return m;
`endif
    endfunction

    function automatic longint model_y(longint x);
        longint acc = x * 128;
        for (int i = 1; i <= 16; i++) acc = acc - A_M[i] * mw[i];
        m_wnew = conv(acc >>> 7, 16);
        acc = B_M[0] * m_wnew;
        for (int i = 1; i <= 16; i++) acc = acc + B_M[i] * mw[i];
        return conv(acc >>> 7, 18);
    endfunction

    task automatic model_commit();
        for (int i = 16; i >= 2; i--) mw[i] = mw[i-1];
        mw[1] = m_wnew;
    endtask

    task automatic model_clear();
        for (int i = 1; i <= 16; i++) mw[i] = 0;
        m_wnew = 0;
        m_sat = 1'b0;
    endtask

    task automatic present(input logic signed [7:0] x, output logic rdy);
        @(negedge clk);
        in_data = x;
        in_valid = 1'b1;
        rdy = in_ready;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) begin cyc = i; break; end
        end
    endtask

    task automatic finish_hs();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (out_data !== 18'sd0) begin failures++; $display("FAIL reset_out_data got=%0d want=0", out_data); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (sat !== 1'b0)       begin failures++; $display("FAIL reset_sat got=%b want=0", sat); end
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_sample();
        logic rdy;
        int cyc;
        logic signed [17:0] exp;
        out_ready = 1'b1;
        sb.push_back(18'(model_y(100)));
        present(8'sd100, rdy);
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL first_accept got=%b want=1", rdy); end
        wait_out(cyc);
        checks++; if (cyc != 34) begin failures++; $display("FAIL first_latency got=%0d want=34", cyc); end
        exp = sb.pop_front();
        checks++; if (out_data !== exp) begin failures++; $display("FAIL first_out_model got=%0d want=%0d", out_data, exp); end
        checks++; if (out_data !== 18'sd4) begin failures++; $display("FAIL first_out_const got=%0d want=4", out_data); end
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL first_ctrl_in_out in_ready=%b busy=%b want 0/1", in_ready, busy); end
        finish_hs();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL first_after_hs out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
        checks++; if (dut.w[1] !== 16'sd100) begin failures++; $display("FAIL first_w1 got=%0d want=100", dut.w[1]); end
    endtask

    task automatic test_second_sample();
        logic rdy;
        int cyc;
        logic signed [17:0] exp;
        sb.push_back(18'(model_y(0)));
        present(8'sd0, rdy);
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL second_accept got=%b want=1", rdy); end
        wait_out(cyc);
        exp = sb.pop_front();
        checks++; if (out_data !== exp) begin failures++; $display("FAIL second_out_model got=%0d want=%0d", out_data, exp); end
        checks++; if (out_data !== -18'sd5) begin failures++; $display("FAIL second_out_const got=%0d want=-5", out_data); end
        checks++; if (dut.w_new !== -16'sd100) begin failures++; $display("FAIL second_w_new got=%0d want=-100", dut.w_new); end
        finish_hs();
    endtask

    task automatic test_backpressure();
        logic rdy;
        int cyc;
        logic signed [17:0] exp;
        out_ready = 1'b0;
        sb.push_back(18'(model_y(-77)));
        present(-8'sd77, rdy);
        checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL bp_accept got=%b want=1", rdy); end
        wait_out(cyc);
        checks++; if (cyc != 34) begin failures++; $display("FAIL bp_latency got=%0d want=34", cyc); end
        exp = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_hold cycle=%0d got=%b want=1", i, out_valid); end
            checks++; if (out_data !== exp) begin failures++; $display("FAIL bp_data_hold cycle=%0d got=%0d want=%0d", i, out_data, exp); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cycle=%0d got=%b want=0", i, in_ready); end
            checks++; if (dut.w[1] !== 16'(mw[1])) begin failures++; $display("FAIL bp_w1_frozen cycle=%0d got=%0d want=%0d", i, dut.w[1], mw[1]); end
        end
        out_ready = 1'b1;
        finish_hs();
        checks++; if (dut.w[1] !== 16'(mw[1]) || dut.w[2] !== 16'(mw[2])) begin failures++; $display("FAIL bp_shift w1=%0d w2=%0d want %0d %0d", dut.w[1], dut.w[2], mw[1], mw[2]); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_drop got=%b want=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic rdy;
        int cyc;
        logic signed [7:0] x;
        logic signed [17:0] exp;
        out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            x = 8'($urandom_range(0, 255));
            sb.push_back(18'(model_y(longint'(x))));
            present(x, rdy);
            checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL b2b_accept n=%0d got=%b want=1", n, rdy); end
            wait_out(cyc);
            exp = sb.pop_front();
            checks++; if (out_data !== exp || cyc != 34) begin failures++; $display("FAIL b2b_out n=%0d x=%0d got=%0d want=%0d latency=%0d", n, x, out_data, exp, cyc); end
            finish_hs();
        end
        checks++; if (sat !== m_sat) begin failures++; $display("FAIL b2b_sat got=%b want=%b", sat, m_sat); end
    endtask

    task automatic test_flush();
        logic rdy;
        int cyc;
        int seen;
        logic signed [17:0] exp;
        present(8'sd50, rdy);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if (dut.k !== 5'd5 || dut.state !== FB) begin failures++; $display("FAIL flush_setup k=%0d state=%0d want k=5 FB", dut.k, dut.state); end
        flush = 1'b1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
        @(posedge clk);
        #1 flush = 1'b0;
        model_clear();
        @(negedge clk);
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_idle busy=%b out_valid=%b in_ready=%b want 0/0/1", busy, out_valid, in_ready); end
        checks++; if (sat !== 1'b0 || dut.w[1] !== 16'sd0) begin failures++; $display("FAIL flush_clear sat=%b w1=%0d want 0/0", sat, dut.w[1]); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL flush_no_output got=%0d want=0", seen); end
        sb.push_back(18'(model_y(100)));
        present(8'sd100, rdy);
        wait_out(cyc);
        exp = sb.pop_front();
        checks++; if (out_data !== exp || out_data !== 18'sd4) begin failures++; $display("FAIL flush_recover got=%0d want=%0d (4)", out_data, exp); end
        finish_hs();
    endtask

    task automatic test_config();
        int cyc;
        logic signed [7:0] exp_d;
        logic exp_s;
`ifdef IIR_SEQ_SAT_EN
        exp_d = 8'sd127;
        exp_s = 1'b1;
`else
        exp_d = -8'sd6;
        exp_s = 1'b0;
`endif
        @(negedge clk);
        in_data2 = 8'sd127;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1 in_valid2 = 1'b0;
        cyc = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid2) begin cyc = i; break; end
        end
        checks++; if (cyc != 34) begin failures++; $display("FAIL cfg_latency got=%0d want=34", cyc); end
        checks++; if (out_data2 !== exp_d) begin failures++; $display("FAIL cfg_out got=%0d want=%0d", out_data2, exp_d); end
        checks++; if (sat2 !== exp_s) begin failures++; $display("FAIL cfg_sat got=%b want=%b", sat2, exp_s); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic rdy;
        int nz;
        int seen;
        present(8'sd90, rdy);
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++; if (dut.state !== FF) begin failures++; $display("FAIL rmid_setup state=%0d want FF", dut.state); end
        checks++; if (dut.w[1] === 16'sd0) begin failures++; $display("FAIL rmid_nonzero_line w1=%0d want nonzero", dut.w[1]); end
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rmid_ctrl out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
        nz = 0;
        for (int i = 1; i <= 16; i++) if (dut.w[i] !== 16'sd0) nz++;
        if (dut.w_new !== 16'sd0) nz++;
        checks++; if (nz != 0) begin failures++; $display("FAIL rmid_line_zero nonzero_words=%0d want=0", nz); end
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL rmid_no_output got=%0d want=0", seen); end
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        flush2 = 1'b0;
        in_data2 = '0;
        in_valid2 = 1'b0;
        out_ready2 = 1'b1;
        m_wnew = 0;
        m_sat = 1'b0;
        test_reset();
        test_first_sample();
        test_second_sample();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_config();
        test_reset_mid();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_drained left=%0d want=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
